// File: rtl/updown_counter_n.sv
// Parametrised synchronous up/down counter with P/T enables and ripple carry/borrow.
// Cascades like 74x163/74x169 parts: rco of one stage drives t of the next.
module updown_counter_n #(
  parameter int N   = 4,
  parameter int MOD = 2 ** N,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         sclr,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         p,
  input  logic         t,
  input  logic         up,
  output logic [N-1:0] q,
  output logic         rco
);

  localparam int           MAX_INT = MOD - 1;
  localparam logic [N-1:0] MAX_VAL = MAX_INT[N-1:0];
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] q_reg;
  logic [N-1:0] q_next;
  logic [N-1:0] tc;

  always_comb begin
    q_next = q_reg;
    if (sclr) begin
      q_next = '0;
    end else if (load) begin
      q_next = d;
    end else if (p && t) begin
      if (up) begin
        if (q_reg < MAX_VAL) begin
          q_next = q_reg + ONE;
        end else if (SAT == 0) begin
          q_next = '0;
        end else begin
          // Saturating: terminal value holds, out-of-range loads snap back to it.
          q_next = MAX_VAL;
        end
      end else begin
        if (q_reg != '0) begin
          q_next = q_reg - ONE;
        end else if (SAT == 0) begin
          q_next = MAX_VAL;
        end else begin
          q_next = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  // Terminal value tracks up combinationally, so rco follows a direction change at once.
  assign tc  = up ? MAX_VAL : '0;
  assign q   = q_reg;
  assign rco = t && (q_reg == tc);

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n: three single-stage configurations plus an 8-bit cascade,
// directed test-plan sequences followed by randomized stimulus against an arithmetic model.
module tb_updown_counter_n;

  logic       clk;
  logic       clr, sclr, load, p, t, up;
  logic [3:0] d;
  logic [3:0] q16, q10, qs, qc0, qc1;
  logic       r16, r10, rs, rc0, rc1;

  int passed = 0;
  int total  = 0;
  bit cmp_en = 0;

  // Model state: plain integers per instance, cascade held as one 8-bit value.
  int m16, m10, ms, mc;

  updown_counter_n #(.N(4), .MOD(16), .SAT(0)) u16 (
    .clk(clk), .clr(clr), .sclr(sclr), .load(load), .d(d),
    .p(p), .t(t), .up(up), .q(q16), .rco(r16));
  updown_counter_n #(.N(4), .MOD(10), .SAT(0)) u10 (
    .clk(clk), .clr(clr), .sclr(sclr), .load(load), .d(d),
    .p(p), .t(t), .up(up), .q(q10), .rco(r10));
  updown_counter_n #(.N(4), .MOD(10), .SAT(1)) us (
    .clk(clk), .clr(clr), .sclr(sclr), .load(load), .d(d),
    .p(p), .t(t), .up(up), .q(qs), .rco(rs));
  updown_counter_n #(.N(4), .MOD(16), .SAT(0)) c0 (
    .clk(clk), .clr(clr), .sclr(sclr), .load(load), .d(d),
    .p(p), .t(t), .up(up), .q(qc0), .rco(rc0));
  updown_counter_n #(.N(4), .MOD(16), .SAT(0)) c1 (
    .clk(clk), .clr(clr), .sclr(sclr), .load(load), .d(d),
    .p(p), .t(rc0), .up(up), .q(qc1), .rco(rc1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int nxt(input int qv, input int md, input int sat);
    if (sclr) return 0;
    if (load) return int'(d);
    if (!(p && t)) return qv;
    if (up) begin
      if (qv < md - 1) return qv + 1;
      return (sat == 0) ? 0 : md - 1;
    end
    if (qv > 0) return qv - 1;
    return (sat == 0) ? md - 1 : 0;
  endfunction

  function automatic int exp_rco(input int qv, input int md);
    return (t && qv == (up ? md - 1 : 0)) ? 1 : 0;
  endfunction

  task automatic model_update();
    if (clr) begin
      m16 = 0; m10 = 0; ms = 0; mc = 0;
    end else begin
      m16 = nxt(m16, 16, 0);
      m10 = nxt(m10, 10, 0);
      ms  = nxt(ms, 10, 1);
      if (sclr) mc = 0;
      else if (load) mc = int'(d) * 17;
      else if (p && t) mc = up ? (mc + 1) % 256 : (mc + 255) % 256;
    end
  endtask

  // One edge: model samples the same inputs the DUT sees, return on the falling edge.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      @(negedge clk);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (cmp_en) begin
      chk("q16", int'(q16), m16);
      chk("rco16", int'(r16), exp_rco(m16, 16));
      chk("q10", int'(q10), m10);
      chk("rco10", int'(r10), exp_rco(m10, 10));
      chk("qsat", int'(qs), ms);
      chk("rcosat", int'(rs), exp_rco(ms, 10));
      chk("qcasc", int'({qc1, qc0}), mc);
      chk("rco_c0", int'(rc0), exp_rco(mc % 16, 16));
      chk("rco_c1", int'(rc1), exp_rco(mc, 256));
    end
  end

  initial begin
    clr = 1'b1; sclr = 0; load = 0; p = 0; t = 1; up = 0; d = '0;
    m16 = 0; m10 = 0; ms = 0; mc = 0;
    #12;
    chk("reset_q16", int'(q16), 0);
    chk("reset_rco_down", int'(r16), 1);
    chk("reset_qcasc", int'({qc1, qc0}), 0);
    @(negedge clk);
    clr = 1'b0;
    cmp_en = 1;

    // Async clear mid-cycle, then count resumes immediately.
    load = 1; d = 4'd9; cyc();
    load = 0;
    chk("loaded9", int'(q16), 9);
    #2 clr = 1'b1; m16 = 0; m10 = 0; ms = 0; mc = 0;
    #1 chk("async_clr_q", int'(q16), 0);
    @(negedge clk);
    clr = 0; p = 1; t = 1; up = 1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("post_clr_step", int'(q16), i);
    end

    // Up wrap with rco at 15.
    sclr = 1; cyc(); sclr = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      chk("wrap_q", int'(q16), i % 16);
      chk("wrap_rco", int'(r16), (i % 16 == 15) ? 1 : 0);
    end
    cyc(15);
    chk("at15", int'(q16), 15);
    t = 0;
    #1 chk("rco_t_low", int'(r16), 0);
    cyc();
    chk("hold_t_low", int'(q16), 15);
    t = 1;

    // Decade down with load, including an out-of-range load.
    load = 1; d = 4'd2; cyc(); load = 0;
    chk("dec_load2", int'(q10), 2);
    up = 0;
    #1 chk("dec_rco_at2", int'(r10), 0);
    begin
      int exp_seq[4] = '{1, 0, 9, 8};
      for (int i = 0; i < 4; i++) begin
        cyc();
        chk("dec_down", int'(q10), exp_seq[i]);
        chk("dec_rco", int'(r10), (exp_seq[i] == 0) ? 1 : 0);
      end
    end
    load = 1; d = 4'd12; cyc(); load = 0;
    for (int i = 11; i >= 9; i--) begin
      cyc();
      chk("dec_oor_down", int'(q10), i);
    end

    // Saturation.
    load = 1; d = 4'd7; up = 1; cyc(); load = 0;
    begin
      int sat_seq[4] = '{8, 9, 9, 9};
      for (int i = 0; i < 4; i++) begin
        cyc();
        chk("sat_up", int'(qs), sat_seq[i]);
      end
    end
    up = 0; cyc();
    chk("sat_turn", int'(qs), 8);
    cyc(8);
    chk("sat_at0", int'(qs), 0);
    cyc();
    chk("sat_hold0", int'(qs), 0);
    load = 1; d = 4'd13; cyc(); load = 0; up = 1;
    cyc();
    chk("sat_oor_up", int'(qs), 9);
    chk("nosat_oor_up", int'(q10), 0);

    // Priority: sclr over load, load over count.
    sclr = 1; load = 1; d = 4'd5; cyc();
    chk("prio_sclr", int'(q16), 0);
    sclr = 0; cyc();
    chk("prio_load", int'(q16), 5);
    load = 0;

    // Cascade: 255 counts from 0 reach 0xFF, next edge wraps.
    sclr = 1; cyc(); sclr = 0;
    cyc(255);
    chk("casc_ff", int'({qc1, qc0}), 255);
    chk("casc_rco0", int'(rc0), 1);
    chk("casc_rco1", int'(rc1), 1);
    cyc();
    chk("casc_wrap", int'({qc1, qc0}), 0);

    // Randomized traffic including occasional async clears.
    for (int i = 0; i < 400; i++) begin
      sclr = ($urandom_range(0, 19) == 0);
      load = ($urandom_range(0, 9) == 0);
      d    = 4'($urandom_range(0, 15));
      p    = ($urandom_range(0, 7) != 0);
      t    = ($urandom_range(0, 7) != 0);
      up   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) begin
        clr = 1; m16 = 0; m10 = 0; ms = 0; mc = 0;
        #1 chk("rand_async_q", int'(q10), 0);
        chk("rand_async_rco", int'(r16), (t && !up) ? 1 : 0);
      end
      cyc();
      clr = 0;
    end

    cmp_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
